// File: rtl/sweep_seq_pkg.sv
// Shared types and constants for the sweep sequencer: FSM states, table field
// codes and the default ARM watchdog length.
package sweep_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } seq_state_t;

    localparam logic [2:0] FLD_START   = 3'd0;
    localparam logic [2:0] FLD_STEP    = 3'd1;
    localparam logic [2:0] FLD_STEPS   = 3'd2;
    localparam logic [2:0] FLD_REPEATS = 3'd3;
    localparam logic [2:0] FLD_UPDIR   = 3'd4;

    localparam int ARM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/sweep_seg_table.sv
// Segment parameter table: NSEG entries of five fields, one field-addressed
// write port and an asynchronous whole-entry read port.
module sweep_seg_table
    import sweep_seq_pkg::*;
#(
    parameter int NSEG = 8,
    parameter int DW   = 12
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_wr_en,
    input  logic [$clog2(NSEG)-1:0] i_wr_addr,
    input  logic [2:0]              i_wr_field,
    input  logic [DW-1:0]           i_wr_data,
    input  logic [$clog2(NSEG)-1:0] i_rd_addr,
    output logic [DW-1:0]           o_start,
    output logic [DW-1:0]           o_step,
    output logic [DW-1:0]           o_steps,
    output logic [DW-1:0]           o_repeats,
    output logic                    o_updir
);

    logic [DW-1:0] start_q   [NSEG];
    logic [DW-1:0] step_q    [NSEG];
    logic [DW-1:0] steps_q   [NSEG];
    logic [DW-1:0] repeats_q [NSEG];
    logic          updir_q   [NSEG];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            start_q   <= '{default: '0};
            step_q    <= '{default: '0};
            steps_q   <= '{default: '0};
            repeats_q <= '{default: '0};
            updir_q   <= '{default: 1'b0};
        end else if (i_wr_en) begin
            // Field codes 5..7 are reserved and silently ignored.
            case (i_wr_field)
                FLD_START:   start_q[i_wr_addr]   <= i_wr_data;
                FLD_STEP:    step_q[i_wr_addr]    <= i_wr_data;
                FLD_STEPS:   steps_q[i_wr_addr]   <= i_wr_data;
                FLD_REPEATS: repeats_q[i_wr_addr] <= i_wr_data;
                FLD_UPDIR:   updir_q[i_wr_addr]   <= i_wr_data[0];
                default:     ;
            endcase
        end
    end

    assign o_start   = start_q[i_rd_addr];
    assign o_step    = step_q[i_rd_addr];
    assign o_steps   = steps_q[i_rd_addr];
    assign o_repeats = repeats_q[i_rd_addr];
    assign o_updir   = updir_q[i_rd_addr];

endmodule

// File: rtl/sweep_sequencer.sv
// Walks the segment table, loading each segment into the sweep engine and
// waiting for it to finish, for a programmable number of passes.
//   state | meaning
//   IDLE  | engine held in reset, waiting for go; table writable
//   LOAD  | latch table[idx] onto the engine parameter outputs
//   ARM   | engine released, waiting for it to report stepping (watchdog)
//   RUN   | engine stepping, waiting for it to finish
//   NEXT  | advance segment index / pass counter
//   DONE  | one-cycle completion pulse
module sweep_sequencer
    import sweep_seq_pkg::*;
#(
    parameter int NSEG        = 8,
    parameter int DW          = 12,
    parameter int ARM_TIMEOUT = ARM_TIMEOUT_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_go,
    input  logic                    i_abort,
    input  logic [$clog2(NSEG):0]   i_nseg,
    input  logic [7:0]              i_loops,
    input  logic                    i_wr_en,
    input  logic [$clog2(NSEG)-1:0] i_wr_addr,
    input  logic [2:0]              i_wr_field,
    input  logic [DW-1:0]           i_wr_data,
    input  logic                    i_sw_stepping,
    output logic                    o_sw_reset,
    output logic                    o_sw_updirection,
    output logic [DW-1:0]           o_sw_start,
    output logic [DW-1:0]           o_sw_step,
    output logic [DW-1:0]           o_sw_steps,
    output logic [DW-1:0]           o_sw_repeats,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_timeout,
    output logic [$clog2(NSEG)-1:0] o_seg_idx,
    output logic [7:0]              o_loop_cnt
);

    localparam int AW = $clog2(NSEG);
    localparam int NW = AW + 1;
    localparam int TW = $clog2(ARM_TIMEOUT) + 1;

    seq_state_t    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    loop_q, loop_d;
    logic [NW-1:0] nseg_q, nseg_d;
    logic [7:0]    loops_q, loops_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, busy_d;
    logic          sw_reset_q, sw_reset_d;
    logic          sw_updir_q, sw_updir_d;
    logic [DW-1:0] sw_start_q, sw_start_d;
    logic [DW-1:0] sw_step_q, sw_step_d;
    logic [DW-1:0] sw_steps_q, sw_steps_d;
    logic [DW-1:0] sw_repeats_q, sw_repeats_d;

    logic [DW-1:0] tbl_start, tbl_step, tbl_steps, tbl_repeats;
    logic          tbl_updir;
    logic          nseg_ok;

    sweep_seg_table #(
        .NSEG (NSEG),
        .DW   (DW)
    ) u_table (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_wr_en    (i_wr_en && (state_q == ST_IDLE)),
        .i_wr_addr  (i_wr_addr),
        .i_wr_field (i_wr_field),
        .i_wr_data  (i_wr_data),
        .i_rd_addr  (idx_q),
        .o_start    (tbl_start),
        .o_step     (tbl_step),
        .o_steps    (tbl_steps),
        .o_repeats  (tbl_repeats),
        .o_updir    (tbl_updir)
    );

    assign nseg_ok = (i_nseg != '0) && (i_nseg <= NW'(NSEG));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        loop_d       = loop_q;
        nseg_d       = nseg_q;
        loops_d      = loops_q;
        timer_d      = timer_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        sw_updir_d   = sw_updir_q;
        sw_start_d   = sw_start_q;
        sw_step_d    = sw_step_q;
        sw_steps_d   = sw_steps_q;
        sw_repeats_d = sw_repeats_q;

        case (state_q)
            ST_IDLE: begin
                if (i_go && !i_abort) begin
                    if (nseg_ok) begin
                        state_d = ST_LOAD;
                        idx_d   = '0;
                        loop_d  = '0;
                        nseg_d  = i_nseg;
                        loops_d = i_loops;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                sw_updir_d   = tbl_updir;
                sw_start_d   = tbl_start;
                sw_step_d    = tbl_step;
                sw_steps_d   = tbl_steps;
                sw_repeats_d = tbl_repeats;
                timer_d      = TW'(ARM_TIMEOUT - 1);
                state_d      = ST_ARM;
            end
            ST_ARM: begin
                if (i_sw_stepping) begin
                    state_d = ST_RUN;
                end else if (timer_q == '0) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (!i_sw_stepping) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (({1'b0, idx_q} + NW'(1)) < nseg_q) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_LOAD;
                end else begin
                    idx_d  = '0;
                    loop_d = loop_q + 8'd1;
                    // loops==0 never matches, so the pass counter simply wraps.
                    if ((loops_q != 8'd0) && (loop_d == loops_q)) state_d = ST_DONE;
                    else                                          state_d = ST_LOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (i_abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            idx_d     = idx_q;
            loop_d    = loop_q;
            timeout_d = 1'b0;
        end

        done_d     = done_d || (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
        sw_reset_d = !((state_d == ST_ARM) || (state_d == ST_RUN));
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            loop_q       <= '0;
            nseg_q       <= '0;
            loops_q      <= '0;
            timer_q      <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            sw_reset_q   <= 1'b1;
            sw_updir_q   <= 1'b0;
            sw_start_q   <= '0;
            sw_step_q    <= '0;
            sw_steps_q   <= '0;
            sw_repeats_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            loop_q       <= loop_d;
            nseg_q       <= nseg_d;
            loops_q      <= loops_d;
            timer_q      <= timer_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            sw_reset_q   <= sw_reset_d;
            sw_updir_q   <= sw_updir_d;
            sw_start_q   <= sw_start_d;
            sw_step_q    <= sw_step_d;
            sw_steps_q   <= sw_steps_d;
            sw_repeats_q <= sw_repeats_d;
        end
    end

    assign o_sw_reset       = sw_reset_q;
    assign o_sw_updirection = sw_updir_q;
    assign o_sw_start       = sw_start_q;
    assign o_sw_step        = sw_step_q;
    assign o_sw_steps       = sw_steps_q;
    assign o_sw_repeats     = sw_repeats_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_timeout        = timeout_q;
    assign o_seg_idx        = idx_q;
    assign o_loop_cnt       = loop_q;

endmodule

// File: doc/sweep_sequencer.md
SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 Parameter NSEG, default 8: number of segment-table entries (power of two).
REQ-002 Parameter DW, default 12: DAC word width.
REQ-003 Parameter ARM_TIMEOUT, default 16: maximum cycles in ARM waiting for i_sw_stepping.
REQ-004 i_clk  in  1  single clock; all logic rising-edge.
REQ-005 i_reset_n  in  1  synchronous, active-low reset.
REQ-006 i_go  in  1  start-run request, sampled in IDLE only.
REQ-007 i_abort  in  1  abort request, any state.
REQ-008 i_nseg  in  log2(NSEG)+1  segments per pass (1..NSEG).
REQ-009 i_loops  in  8  passes over the table; 0 means run until abort.
REQ-010 i_wr_en / i_wr_addr / i_wr_field / i_wr_data  in  1 / log2(NSEG) / 3 / DW  table write port.
REQ-011 i_sw_stepping  in  1  sweep engine busy flag.
REQ-012 o_sw_reset  out  1  active-high hold-in-reset to sweep engine.
REQ-013 o_sw_updirection, o_sw_start, o_sw_step, o_sw_steps, o_sw_repeats  out  1/DW/DW/DW/DW  registered segment parameters.
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_done / o_timeout  out  1 / 1  one-cycle pulses.
REQ-016 o_seg_idx / o_loop_cnt  out  log2(NSEG) / 8  current segment and completed passes.

Function
REQ-017 Table fields: 0 start, 1 step, 2 steps, 3 repeats, 4 updirection (bit 0); fields 5-7 ignored.
REQ-018 Write takes effect the cycle after i_wr_en; writes while o_busy=1 are dropped.
REQ-019 States IDLE, LOAD, ARM, RUN, NEXT, DONE.
REQ-020 IDLE: o_sw_reset=1; i_go=1 with 1<=i_nseg<=NSEG -> LOAD, idx=0, loop_cnt=0; i_nseg out of range -> stay IDLE, pulse o_done next cycle.
REQ-021 LOAD (1 cycle): o_sw_* registered from table[idx], o_sw_reset=1 -> ARM.
REQ-022 ARM: o_sw_reset=0; i_sw_stepping=1 -> RUN; ARM_TIMEOUT cycles without it -> IDLE with o_timeout pulse.
REQ-023 RUN: o_sw_reset=0; i_sw_stepping=0 -> NEXT.
REQ-024 NEXT (1 cycle): o_sw_reset=1; idx<i_nseg-1 -> idx+1, LOAD; else loop_cnt+1, idx=0; if i_loops!=0 and loop_cnt+1==i_loops -> DONE, else LOAD.
REQ-025 DONE (1 cycle): o_done=1, o_sw_reset=1 -> IDLE; o_loop_cnt keeps final value until next i_go.
REQ-026 i_abort=1 in any non-IDLE state -> IDLE next cycle, o_sw_reset=1, no o_done; abort has priority over every other transition.
REQ-027 i_go while busy is ignored; i_go and i_abort together in IDLE -> stay IDLE.
REQ-028 i_loops=0: loop_cnt wraps 255->0 and the run continues.
REQ-029 i_nseg, i_loops are sampled on leaving IDLE; later changes have no effect until next run.
REQ-030 Go-to-first-LOAD latency 1 cycle; segment-to-segment gap (RUN exit to next ARM) 2 cycles.

Reset
REQ-031 i_reset_n=0 at a clock edge: state IDLE, o_sw_reset=1, all other outputs 0, table all zero.
REQ-032 Reset mid-run behaves as abort and additionally clears the table.

Structure
REQ-033 Package sweep_seq_pkg holds the state enumeration, field codes and the ARM_TIMEOUT default.
REQ-034 Sub-module sweep_seg_table: NSEG x 5-field register file, one write port, one async read port.
REQ-035 Outputs are registered; no combinational path from inputs to outputs.

Verification
REQ-036 Two segments (0/1/4095/512 up, 4095/1/4095/512 down), i_nseg=2, i_loops=1, stepping model -> two LOAD/ARM/RUN visits, o_done once, o_loop_cnt=1.
REQ-037 Same table, i_loops=3 -> six segment runs, idx sequence 0,1,0,1,0,1, o_done after the sixth.
REQ-038 i_sw_stepping held 0 -> o_timeout pulse exactly 16 cycles after ARM entry, back to IDLE, o_sw_reset=1.
REQ-039 i_abort in RUN of segment 1 -> IDLE next cycle, o_busy=0, no o_done.
REQ-040 Write start=100 to seg 0 while busy -> dropped; same write in IDLE -> next run shows o_sw_start=100.
REQ-041 i_go with i_nseg=0 -> no LOAD, o_done pulse, o_busy stays 0.
